burst_wdata_forward: RTL

- Write-data stage directly downstream of the burst detector.
- For each burst length popped from the detector's burst-length FIFO, it forwards burst_len+1 beats from the write-data FIFO onto the AXI W channel and asserts WLAST on the final beat.
- Keeps W-channel beat framing consistent with the {burst_len, base_addr} AW entries issued by the detector.
- Sustains one beat per cycle, including across burst boundaries.

---
 rtl/burst_wdata_forward.sv | 131 +++++++++++++
 1 files changed

// File: rtl/burst_wdata_forward.sv
`default_nettype none
// ============================================================================
//  Module      : burst_wdata_forward
//  Description : AXI write-data stage that sits behind the burst detector.
//                For every burst length L popped from the burst-length FIFO
//                it forwards L+1 beats from the write-data FIFO onto the W
//                channel. WLAST is asserted on the final beat of each burst.
//                When one burst ends, the next burst length is fetched in the
//                same cycle, so the W channel can run at one beat per clock
//                across burst boundaries.
//
//  Ports:
//    clk, rst            clock, synchronous active-high reset
//    burst_len_dout      head of the burst-length FIFO (L means L+1 beats)
//    burst_len_empty_n   burst-length FIFO holds at least one entry
//    burst_len_read      pop strobe for the burst-length FIFO (combinational)
//    data_dout           head of the write-data FIFO
//    data_empty_n        write-data FIFO holds at least one entry
//    data_read           pop strobe for the write-data FIFO (combinational)
//    m_axi_w*            AXI W channel; wdata, wlast and wvalid are registered
//
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_wdata_forward #(
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_LEN_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BURST_LEN_WIDTH-1:0]  burst_len_dout,
    input  logic                        burst_len_empty_n,
    output logic                        burst_len_read,
    input  logic [DATA_WIDTH-1:0]       data_dout,
    input  logic                        data_empty_n,
    output logic                        data_read,
    output logic [DATA_WIDTH-1:0]       m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]     m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE = 1'b1;

    localparam logic [BURST_LEN_WIDTH-1:0] c_REM_ZERO = '0;
    localparam logic [BURST_LEN_WIDTH-1:0] c_REM_ONE  = {{(BURST_LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]                 r_state;
    // Beats still to be popped after the one currently at the FIFO head.
    logic [BURST_LEN_WIDTH-1:0] r_remaining;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic                       r_wlast;
    logic                       r_wvalid;

    logic w_slot_free;
    logic w_data_read;
    logic w_last_pop;
    logic w_len_read;

    // The output register can take a new beat when it is empty or its
    // current beat is being accepted this cycle.
    assign w_slot_free = !r_wvalid || m_axi_wready;

    assign w_data_read = !rst && (r_state == c_ST_ACTIVE) && w_slot_free && data_empty_n;

    // Popping the final beat of the burst this cycle.
    assign w_last_pop  = w_data_read && (r_remaining == c_REM_ZERO);

    // A burst length is fetched either while idle or in the very cycle the
    // last beat of the current burst leaves the data FIFO, which removes the
    // bubble between consecutive bursts.
    assign w_len_read  = !rst && burst_len_empty_n &&
                         ((r_state == c_ST_IDLE) || w_last_pop);

    assign burst_len_read = w_len_read;
    assign data_read      = w_data_read;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_remaining <= c_REM_ZERO;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_len_read) begin
                        r_remaining <= burst_len_dout;
                        r_state     <= c_ST_ACTIVE;
                    end
                end
                c_ST_ACTIVE: begin
                    if (w_data_read) begin
                        if (r_remaining != c_REM_ZERO) begin
                            r_remaining <= r_remaining - c_REM_ONE;
                        end else if (w_len_read) begin
                            r_remaining <= burst_len_dout;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // W output register. A beat is held untouched while wready is low; it is
    // retired when accepted without a replacement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdata  <= '0;
            r_wlast  <= 1'b0;
            r_wvalid <= 1'b0;
        end else if (w_data_read) begin
            r_wdata  <= data_dout;
            r_wlast  <= (r_remaining == c_REM_ZERO);
            r_wvalid <= 1'b1;
        end else if (r_wvalid && m_axi_wready) begin
            r_wvalid <= 1'b0;
        end
    end

    assign m_axi_wdata  = r_wdata;
    assign m_axi_wlast  = r_wlast;
    assign m_axi_wvalid = r_wvalid;
    assign m_axi_wstrb  = '1;

endmodule
`default_nettype wire
